compare_and_swap: RTL and testbench
===================================

// Module: compare_and_swap
//
// PURPOSE
// - Two-element compare-and-swap cell, the basic building block of sorting
//   networks. Compares a selectable bit field (key) of two words; if element 0's
//   key is larger, the two words are exchanged.
// - Conditional swap on tie: when enabled, identical words can be swapped on request.
// - Reports whether a swap occurred.
// - Default configuration is purely combinational. An optional output register
//   is available for pipelined networks.
//
// PARAMETERS
// - width_p               default 8          bits per element
// - t_p                   default width_p-1  top (MSB) index of key field, inclusive
// - b_p                   default 0          bottom (LSB) index of key field, inclusive
// - cond_swap_on_equal_p  default 0          1 = honour swap_on_equal_i on ties
// - pipeline_p            default 0          0 = combinational; 1 = registered outputs
// - Legal range is 0 <= b_p <= t_p <= width_p-1. Any other combination is an
//   elaboration-time error.
//
// PORTS
// - clk              in   1              clock; used only when pipeline_p=1
// - reset            in   1              synchronous, active-high; used only when pipeline_p=1
// - data_i           in   [1:0][width_p-1:0]  two elements, packed; data_i[0], data_i[1]
// - swap_on_equal_i  in   1              request swap on tie (needs cond_swap_on_equal_p=1)
// - data_o           out  [1:0][width_p-1:0]  ordered elements
// - swapped_o        out  1              1 = elements were exchanged
//
// BEHAVIOUR
// - Key field definition:
//     k0 = data_i[0][t_p:b_p]
//     k1 = data_i[1][t_p:b_p]
// - Keys are compared as unsigned values. Bits outside [t_p:b_p] never affect
//   the greater-than test.
// - Swap condition:
//     swap = (k0 > k1)
//          | (cond_swap_on_equal_p & swap_on_equal_i & (data_i[0] == data_i[1]))
// - The tie test compares the full width_p-bit words, not just the key field.
// - When cond_swap_on_equal_p=0, swap_on_equal_i is ignored.
// - Outputs:
//     swap=1 : data_o[1] = data_i[0], data_o[0] = data_i[1]
//     swap=0 : data_o = data_i
//     swapped_o = swap
// - Net effect: the larger key always ends up in slot 1 (ascending order).
// - pipeline_p=0:
//   - Zero latency; no state.
//   - clk and reset are ignored.
//   - Outputs are valid in the same cycle as the inputs.
// - pipeline_p=1:
//   - Latency is 1 cycle. data_o and swapped_o are registered on posedge clk.
//   - While reset is high, data_o = 0 and swapped_o = 0.
//   - There is no valid/ready handshake. A new input is accepted every cycle.
//   - Reset asserted mid-stream discards the in-flight result.
// - Boundary cases:
//   - t_p == b_p gives a single-bit key.
//   - A full-width key (t_p = width_p-1, b_p = 0) behaves as a plain unsigned sort.
//   - With identical words, data_o equals data_i whether or not a swap is
//     reported; only swapped_o differs.
//
// STRUCTURE
// - No shared package is needed. The parameter legality check stays local,
//   as a generate-time $error.
// - One natural sub-module is compare_and_swap_key_cmp.
//   - Inputs: two key fields and the tie request.
//   - Output: the swap decision.
//   - The top level holds the 2:1 data muxes and the optional register stage.
//
// TESTING
// - Full-width key, width_p=4, t_p=3, b_p=0:
//     data_i[0]=5, data_i[1]=3  -> swapped_o=1, data_o[1]=5, data_o[0]=3
//     data_i[0]=3, data_i[1]=5  -> swapped_o=0, data_o unchanged
// - Key field only, width_p=4, t_p=2, b_p=1:
//     data_i[0]=4'b0110 (k0=3), data_i[1]=4'b1010 (k1=1)
//     -> swapped_o=1, even though the word 6 < 10
// - Tie, both words 7, cond_swap_on_equal_p=1:
//     swap_on_equal_i=1 -> swapped_o=1, data_o = {7,7}
//     swap_on_equal_i=0 -> swapped_o=0
//     cond_swap_on_equal_p=0 -> swapped_o=0 for any swap_on_equal_i
// - Sweep, width_p=2, t_p=1, b_p=1, both cond_swap_on_equal_p values:
//     data_i[0] counts up from 0, data_i[1] counts down from 2'b11,
//     swap_on_equal_i toggles every cycle
//     -> each cycle, swapped_o and data_o match the swap formula above
// - Illegal parameters (t_p=2 with width_p=2, or b_p > t_p):
//     -> elaboration error; no instance is built
// - pipeline_p=1, reset held for 5 cycles:
//     outputs stay 0 during reset
//     after release, data_i[0]=5, data_i[1]=3 -> data_o = {5,3} and swapped_o=1
//     one cycle later

Source files
------------

// File: rtl/compare_and_swap_pkg.sv
// Shared helpers for the compare-and-swap cell.
// Holds the parameter legality check used at elaboration.
package compare_and_swap_pkg;

  function automatic bit cas_params_ok(
    input int width,
    input int t,
    input int b
  );
    return (width > 0) && (b >= 0) && (b <= t) && (t <= width - 1);
  endfunction

  function automatic int cas_key_w(
    input int t,
    input int b
  );
    return t - b + 1;
  endfunction

endpackage

// File: rtl/compare_and_swap_key_cmp.sv
// Swap decision for one compare-and-swap cell.
// Ports: k0_i/k1_i keys, eq_i full-word tie, swap_on_equal_i, swap_o.
module compare_and_swap_key_cmp #(
  parameter int key_w_p = 8,
  parameter int cond_p  = 0
) (
  input  logic [key_w_p-1:0] k0_i,
  input  logic [key_w_p-1:0] k1_i,
  input  logic               eq_i,
  input  logic               swap_on_equal_i,
  output logic               swap_o
);

  localparam logic cond_lp = (cond_p != 0);

  logic gt;
  logic tie_swap;

  assign gt       = (k0_i > k1_i);
  assign tie_swap = cond_lp & swap_on_equal_i & eq_i;
  assign swap_o   = gt | tie_swap;

endmodule

// File: rtl/compare_and_swap.sv
// Two-element compare-and-swap cell with optional output register.
// Ports: clk, reset, data_i[1:0], swap_on_equal_i, data_o[1:0], swapped_o.
module compare_and_swap
  import compare_and_swap_pkg::*;
#(
  parameter int width_p              = 8,
  parameter int t_p                  = width_p - 1,
  parameter int b_p                  = 0,
  parameter int cond_swap_on_equal_p = 0,
  parameter int pipeline_p           = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0][width_p-1:0] data_i,
  input  logic                    swap_on_equal_i,
  output logic [1:0][width_p-1:0] data_o,
  output logic                    swapped_o
);

  generate
    if (!cas_params_ok(width_p, t_p, b_p)) begin : g_bad
      $error("compare_and_swap: illegal key field t_p=%0d b_p=%0d width_p=%0d",
             t_p, b_p, width_p);
      assign data_o    = '0;
      assign swapped_o = 1'b0;
      logic unused_ok;
      assign unused_ok = ^{clk, reset, data_i, swap_on_equal_i};
    end else begin : g_ok
      localparam int key_w_lp = cas_key_w(t_p, b_p);

      logic                    swap;
      logic                    words_eq;
      logic [1:0][width_p-1:0] data_n;

      // Tie test uses the whole word, not just the key.
      assign words_eq = (data_i[0] == data_i[1]);

      compare_and_swap_key_cmp #(
        .key_w_p (key_w_lp),
        .cond_p  (cond_swap_on_equal_p)
      ) u_cmp (
        .k0_i            (data_i[0][t_p:b_p]),
        .k1_i            (data_i[1][t_p:b_p]),
        .eq_i            (words_eq),
        .swap_on_equal_i (swap_on_equal_i),
        .swap_o          (swap)
      );

      assign data_n[0] = swap ? data_i[1] : data_i[0];
      assign data_n[1] = swap ? data_i[0] : data_i[1];

      if (pipeline_p != 0) begin : g_reg
        always_ff @(posedge clk) begin
          if (reset) begin
            data_o    <= '0;
            swapped_o <= 1'b0;
          end else begin
            data_o    <= data_n;
            swapped_o <= swap;
          end
        end
      end else begin : g_comb
        assign data_o    = data_n;
        assign swapped_o = swap;
        // Clock and reset have no role in the combinational build.
        logic unused_ok;
        assign unused_ok = ^{clk, reset};
      end
    end
  endgenerate

endmodule

// File: tb/tb_compare_and_swap.sv
// Bench for compare_and_swap over several parameter sets.
// Directed cases, a width-2 sweep and random traffic against a model.
module tb_compare_and_swap;

  logic clk = 1'b0;
  logic reset;
  logic [7:0] a;
  logic [7:0] b;
  logic req;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  logic [1:0][3:0] d0, d1, d2, dp;
  logic [1:0][1:0] d3, d4;
  logic [1:0][7:0] dr;
  logic s0, s1, s2, s3, s4, sp, sr;

  compare_and_swap #(.width_p(4), .t_p(3), .b_p(0),
    .cond_swap_on_equal_p(0), .pipeline_p(0)) u0 (
    .clk(clk), .reset(reset), .data_i({b[3:0], a[3:0]}),
    .swap_on_equal_i(req), .data_o(d0), .swapped_o(s0));

  compare_and_swap #(.width_p(4), .t_p(2), .b_p(1),
    .cond_swap_on_equal_p(1), .pipeline_p(0)) u1 (
    .clk(clk), .reset(reset), .data_i({b[3:0], a[3:0]}),
    .swap_on_equal_i(req), .data_o(d1), .swapped_o(s1));

  compare_and_swap #(.width_p(4), .t_p(3), .b_p(0),
    .cond_swap_on_equal_p(1), .pipeline_p(0)) u2 (
    .clk(clk), .reset(reset), .data_i({b[3:0], a[3:0]}),
    .swap_on_equal_i(req), .data_o(d2), .swapped_o(s2));

  compare_and_swap #(.width_p(2), .t_p(1), .b_p(1),
    .cond_swap_on_equal_p(0), .pipeline_p(0)) u3 (
    .clk(clk), .reset(reset), .data_i({b[1:0], a[1:0]}),
    .swap_on_equal_i(req), .data_o(d3), .swapped_o(s3));

  compare_and_swap #(.width_p(2), .t_p(1), .b_p(1),
    .cond_swap_on_equal_p(1), .pipeline_p(0)) u4 (
    .clk(clk), .reset(reset), .data_i({b[1:0], a[1:0]}),
    .swap_on_equal_i(req), .data_o(d4), .swapped_o(s4));

  compare_and_swap #(.width_p(8), .t_p(5), .b_p(2),
    .cond_swap_on_equal_p(1), .pipeline_p(0)) ur (
    .clk(clk), .reset(reset), .data_i({b, a}),
    .swap_on_equal_i(req), .data_o(dr), .swapped_o(sr));

  compare_and_swap #(.width_p(4), .t_p(3), .b_p(0),
    .cond_swap_on_equal_p(1), .pipeline_p(1)) up (
    .clk(clk), .reset(reset), .data_i({b[3:0], a[3:0]}),
    .swap_on_equal_i(req), .data_o(dp), .swapped_o(sp));

  // Result packed as {swapped, slot1, slot0}, slots zero-extended to 8 bits.
  function automatic logic [16:0] model(
    input int w, input int t, input int bl, input int cond,
    input int x0, input int x1, input bit r
  );
    int m0, m1, k0, k1, kmask;
    bit sw;
    m0 = x0 % (1 << w);
    m1 = x1 % (1 << w);
    kmask = (1 << (t - bl + 1)) - 1;
    k0 = (m0 >> bl) & kmask;
    k1 = (m1 >> bl) & kmask;
    sw = (k0 > k1) || ((cond != 0) && r && (m0 == m1));
    if (sw) return {1'b1, 8'(m0), 8'(m1)};
    return {1'b0, 8'(m1), 8'(m0)};
  endfunction

  task automatic check(input string tag, input logic [16:0] obs,
                       input logic [16:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] obs4(input logic s,
                                       input logic [1:0][3:0] d);
    return {s, 8'(d[1]), 8'(d[0])};
  endfunction

  function automatic logic [16:0] obs2(input logic s,
                                       input logic [1:0][1:0] d);
    return {s, 8'(d[1]), 8'(d[0])};
  endfunction

  logic [16:0] exp_p;
  bit rst_now;

  initial begin
    reset = 1'b1;
    a = 8'd5;
    b = 8'd3;
    req = 1'b0;

    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("pipe_reset", {sp, 8'(dp[1]), 8'(dp[0])}, 17'h0);
    end

    reset = 1'b0;
    a = 8'd5;
    b = 8'd3;
    #1;
    check("full_key_5_3", obs4(s0, d0), {1'b1, 8'd5, 8'd3});
    @(posedge clk);
    #1;
    check("pipe_first", obs4(sp, dp), {1'b1, 8'd5, 8'd3});

    a = 8'd3;
    b = 8'd5;
    #1;
    check("full_key_3_5", obs4(s0, d0), {1'b0, 8'd5, 8'd3});

    a = 8'b0110;
    b = 8'b1010;
    req = 1'b0;
    #1;
    check("key_field", obs4(s1, d1), {1'b1, 8'd6, 8'd10});

    a = 8'd7;
    b = 8'd7;
    req = 1'b1;
    #1;
    check("tie_req1", obs4(s2, d2), {1'b1, 8'd7, 8'd7});
    check("tie_nocond", obs4(s0, d0), {1'b0, 8'd7, 8'd7});
    req = 1'b0;
    #1;
    check("tie_req0", obs4(s2, d2), {1'b0, 8'd7, 8'd7});

    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      a = 8'(i % 4);
      b = 8'(3 - (i % 4));
      req = i[0];
      #1;
      check("sweep_c0", obs2(s3, d3), model(2, 1, 1, 0, a, b, req));
      check("sweep_c1", obs2(s4, d4), model(2, 1, 1, 1, a, b, req));
    end

    // Pipe instance now holds the last sweep input; start the random run
    // with a clean expectation by aligning on one extra cycle.
    @(posedge clk);
    #1;
    exp_p = model(4, 3, 0, 1, a, b, req);
    check("pipe_hold", obs4(sp, dp), exp_p);

    for (int i = 0; i < 200; i++) begin
      rst_now = (i == 100) || (i == 101);
      reset = rst_now;
      a = 8'($urandom);
      b = ($urandom_range(0, 3) == 0) ? a : 8'($urandom);
      if ($urandom_range(0, 3) == 0) b[7:4] = a[7:4];
      req = 1'($urandom);
      #1;
      check("rand_full", obs4(s0, d0), model(4, 3, 0, 0, a, b, req));
      check("rand_field", obs4(s1, d1), model(4, 2, 1, 1, a, b, req));
      check("rand_tie", obs4(s2, d2), model(4, 3, 0, 1, a, b, req));
      check("rand_w8", {sr, dr[1], dr[0]}, model(8, 5, 2, 1, a, b, req));
      exp_p = rst_now ? 17'h0 : model(4, 3, 0, 1, a, b, req);
      @(posedge clk);
      #1;
      check("rand_pipe", obs4(sp, dp), exp_p);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
